display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 115 +++++++++++
 tb/tb_display_scan.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Four-digit multiplexed seven-segment scanner: shows save1, save2, res or the
// operator code, one digit per prescaler period, with optional leading-zero blanking.
`timescale 1ns/1ps
module display_scan #(
    parameter int PRESCALE       = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] save1,
    input  logic [15:0] save2,
    input  logic [15:0] res,
    input  logic [3:0]  op_in,
    input  logic [1:0]  sel,
    input  logic        blank_en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        frame_start
);

    localparam logic [15:0] LAST_COUNT = 16'(PRESCALE - 1);
    localparam logic [6:0]  SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]  AN_OFF     = SEG_ACTIVE_LOW ? 4'hF  : 4'h0;
    localparam logic [1:0]  SEL_OP     = 2'b11;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    logic [15:0] count;
    logic [1:0]  idx;
    logic [15:0] frame_q;
    logic [1:0]  sel_q;
    logic        blank_q;

    logic        tick;
    logic        wrap;
    logic [1:0]  nxt_idx;
    logic [15:0] src;
    logic [15:0] nxt_frame;
    logic [1:0]  nxt_sel;
    logic        nxt_blank;
    logic [15:0] upper;
    logic        dig_blank;
    logic [6:0]  seg_hi;
    logic [6:0]  nxt_seg;
    logic [3:0]  nxt_an;

    // The display registers are loaded from the post-tick index and snapshot, so
    // digit 0 of a new frame already shows the freshly latched source.
    // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
    always_comb begin
        tick      = (count == LAST_COUNT);
        wrap      = tick && (idx == 2'd3);
        nxt_idx   = idx + 2'd1;
        case (sel)
            2'b00:   src = save1;
            2'b01:   src = save2;
            2'b10:   src = res;
            default: src = {12'h000, op_in & 4'h3};
        endcase
        nxt_frame = wrap ? src      : frame_q;
        nxt_sel   = wrap ? sel      : sel_q;
        nxt_blank = wrap ? blank_en : blank_q;
        upper     = nxt_frame >> {nxt_idx, 2'b00};
        dig_blank = (nxt_idx != 2'd0) &&
                    ((nxt_sel == SEL_OP) || (nxt_blank && (upper == 16'h0000)));
        seg_hi    = dig_blank ? 7'h00 : hex7(upper[3:0]);
        nxt_seg   = SEG_ACTIVE_LOW ? ~seg_hi : seg_hi;
        nxt_an    = SEG_ACTIVE_LOW ? ~(4'b0001 << nxt_idx) : (4'b0001 << nxt_idx);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= 16'h0000;
            idx         <= 2'd0;
            frame_q     <= 16'h0000;
            sel_q       <= 2'b00;
            blank_q     <= 1'b0;
            seg         <= SEG_OFF;
            an          <= AN_OFF;
            frame_start <= 1'b0;
        end else begin
            count       <= tick ? 16'h0000 : count + 16'h0001;
            frame_start <= wrap;
            if (tick) begin
                idx     <= nxt_idx;
                frame_q <= nxt_frame;
                sel_q   <= nxt_sel;
                blank_q <= nxt_blank;
                seg     <= nxt_seg;
                an      <= nxt_an;
            end
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: a frame-level model predicts each digit update,
// a monitor compares every display change against the queued expectation.
`timescale 1ns/1ps
module tb_display_scan;

    localparam int P = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] save1 = '0, save2 = '0, res = '0;
    logic [3:0]  op_in = '0;
    logic [1:0]  sel = '0;
    logic        blank_en = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        frame_start;

    int compared = 0;
    int mismatched = 0;

    display_scan #(.PRESCALE(P), .SEG_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .save1(save1), .save2(save2), .res(res),
        .op_in(op_in), .sel(sel), .blank_en(blank_en),
        .seg(seg), .an(an), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    exp_t exp_q[$];

    logic [6:0] hex_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Model: counts cycles since reset release; every P-th edge is a tick. Tick k
    // lights digit k mod 4; a frame snapshot of the inputs is taken on ticks lighting digit 0.
    int          n = 0;
    int unsigned snap_frame = 0;
    int unsigned snap_sel = 0;
    bit          snap_blank = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            n = 0;
            snap_frame = 0;
            snap_sel = 0;
            snap_blank = 0;
            exp_q.delete();
        end else begin
            n++;
            if (n % P == 0) begin
                int d;
                int unsigned up;
                bit blank;
                exp_t e;
                d = (n / P) % 4;
                if (d == 0) begin
                    snap_sel = sel;
                    snap_blank = blank_en;
                    case (sel)
                        2'd0: snap_frame = save1;
                        2'd1: snap_frame = save2;
                        2'd2: snap_frame = res;
                        default: snap_frame = op_in % 4;
                    endcase
                end
                up = snap_frame >> (4 * d);
                if (d == 0) blank = 0;
                else if (snap_sel == 3) blank = 1;
                else blank = snap_blank && (up == 0);
                e.cyc = n;
                e.an  = ~(4'(1 << d));
                e.seg = blank ? 7'h7F : ~hex_tab[up % 16];
                e.fs  = (d == 0);
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: any display change, or any queued expectation, is consumed here.
    logic [3:0] last_an = 4'hF;
    logic [6:0] last_seg = 7'h7F;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_an = 4'hF;
            last_seg = 7'h7F;
        end else begin
            bit changed;
            changed = (an !== last_an) || (seg !== last_seg);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check($sformatf("an@%0d", e.cyc), 32'(an), 32'(e.an));
                check($sformatf("seg@%0d", e.cyc), 32'(seg), 32'(e.seg));
                check($sformatf("frame_start@%0d", e.cyc), 32'(frame_start), 32'(e.fs));
            end else if (changed) begin
                check($sformatf("unexpected_update@%0d an", n), 32'(an), 32'(last_an));
            end else begin
                check($sformatf("frame_start_idle@%0d", n), 32'(frame_start), 32'd0);
            end
            last_an = an;
            last_seg = seg;
        end
    end

    task automatic run(input int cycles);
        repeat (cycles) @(negedge clk);
    endtask

    initial begin
        #12;
        check("reset_seg", 32'(seg), 32'h7F);
        check("reset_an", 32'(an), 32'hF);
        check("reset_fs", 32'(frame_start), 32'h0);
        save1 = 16'h12AF;
        sel = 2'b00;
        blank_en = 1'b0;
        run(2);
        rst_n = 1'b1;
        run(40);

        sel = 2'b10; res = 16'h0007; blank_en = 1'b1;
        run(32);
        res = 16'h0000;
        run(32);

        sel = 2'b00; save1 = 16'h1111; blank_en = 1'b0;
        run(26);
        save1 = 16'h2222;
        run(36);

        sel = 2'b11; op_in = 4'b0110;
        run(40);

        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midframe_reset_seg", 32'(seg), 32'h7F);
        check("midframe_reset_an", 32'(an), 32'hF);
        check("midframe_reset_fs", 32'(frame_start), 32'h0);
        run(3);
        rst_n = 1'b1;
        run(24);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0) begin
                save1    = 16'($urandom);
                save2    = 16'($urandom);
                res      = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
                op_in    = 4'($urandom);
                sel      = 2'($urandom);
                blank_en = 1'($urandom);
            end
        end
        run(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
